// File: rtl/baud_gen_frac.sv
// Fractional baud-rate generator: emits oversample, bit-centre and bit-end ticks from an
// integer + fractional clock divisor, with a shadow register for glitch-free rate changes.
module baud_gen_frac #(
  parameter int unsigned NB_DIV           = 16,
  parameter int unsigned NB_FRAC          = 4,
  parameter int unsigned OVERSAMPLE       = 16,
  parameter int unsigned DEFAULT_DIV_INT  = 326,
  parameter int unsigned DEFAULT_DIV_FRAC = 0
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic [NB_DIV-1:0]  i_div_int,
  input  logic [NB_FRAC-1:0] i_div_frac,
  input  logic               i_div_load,
  output logic               o_tick,
  output logic               o_mid_tick,
  output logic               o_bit_tick,
  output logic               o_pending
);

  localparam int unsigned NB_SUB = $clog2(OVERSAMPLE);

  localparam logic [NB_SUB-1:0]  SubLast = NB_SUB'(OVERSAMPLE - 1);
  localparam logic [NB_SUB-1:0]  SubMid  = NB_SUB'(OVERSAMPLE / 2 - 1);
  localparam logic [NB_DIV-1:0]  RstInt  = NB_DIV'(DEFAULT_DIV_INT);
  localparam logic [NB_FRAC-1:0] RstFrac = NB_FRAC'(DEFAULT_DIV_FRAC);
  localparam logic [NB_DIV-1:0]  MinDiv  = NB_DIV'(2);

  logic [NB_DIV-1:0]  act_int_q, act_int_d;
  logic [NB_FRAC-1:0] act_frac_q, act_frac_d;
  logic [NB_DIV-1:0]  shd_int_q, shd_int_d;
  logic [NB_FRAC-1:0] shd_frac_q, shd_frac_d;
  logic [NB_DIV-1:0]  cnt_q, cnt_d;
  logic [NB_FRAC-1:0] acc_q, acc_d;
  logic               carry_q, carry_d;
  logic [NB_SUB-1:0]  sub_q, sub_d;
  logic               pending_q, pending_d;

  logic [NB_DIV-1:0]  eff_int;
  logic [NB_DIV:0]    period;
  logic [NB_DIV:0]    period_m1;
  logic [NB_FRAC:0]   acc_sum;
  logic               tick;
  logic               apply;

  // Clamp keeps the shortest period at 2 cycles; carry stretches a period by one cycle.
  assign eff_int   = (act_int_q < MinDiv) ? MinDiv : act_int_q;
  assign period    = {1'b0, eff_int} + (NB_DIV + 1)'(carry_q);
  assign period_m1 = period - (NB_DIV + 1)'(1);
  assign acc_sum   = {1'b0, acc_q} + {1'b0, act_frac_q};

  // Ticks are masked during reset so a reset cycle never emits a stray strobe.
  assign tick  = i_reset & i_enable & ({1'b0, cnt_q} == period_m1);
  // A pending divisor is taken at a period boundary, or at once while the generator is idle.
  assign apply = pending_q & (tick | ~i_enable);

  always_comb begin
    act_int_d  = act_int_q;
    act_frac_d = act_frac_q;
    shd_int_d  = shd_int_q;
    shd_frac_d = shd_frac_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    carry_d    = carry_q;
    sub_d      = sub_q;
    pending_d  = i_div_load | (pending_q & ~apply);

    if (i_div_load) begin
      shd_int_d  = i_div_int;
      shd_frac_d = i_div_frac;
    end

    if (apply) begin
      act_int_d  = shd_int_q;
      act_frac_d = shd_frac_q;
    end

    if (!i_enable) begin
      cnt_d   = '0;
      acc_d   = '0;
      carry_d = 1'b0;
      sub_d   = '0;
    end else if (tick) begin
      cnt_d = '0;
      sub_d = (sub_q == SubLast) ? '0 : sub_q + 1'b1;
      if (apply) begin
        acc_d   = '0;
        carry_d = 1'b0;
      end else begin
        {carry_d, acc_d} = acc_sum;
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      act_int_q  <= RstInt;
      act_frac_q <= RstFrac;
      shd_int_q  <= RstInt;
      shd_frac_q <= RstFrac;
      cnt_q      <= '0;
      acc_q      <= '0;
      carry_q    <= 1'b0;
      sub_q      <= '0;
      pending_q  <= 1'b0;
    end else begin
      act_int_q  <= act_int_d;
      act_frac_q <= act_frac_d;
      shd_int_q  <= shd_int_d;
      shd_frac_q <= shd_frac_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      carry_q    <= carry_d;
      sub_q      <= sub_d;
      pending_q  <= pending_d;
    end
  end

  assign o_tick     = tick;
  assign o_mid_tick = tick & (sub_q == SubMid);
  assign o_bit_tick = tick & (sub_q == SubLast);
  assign o_pending  = pending_q;

endmodule
